// File: rtl/instr_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_encoder: MIPS-32 instruction word encoder with delay-slot NOPs    |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        slot_en,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  typedef enum logic [0:0] {ENC = 1'b0, SLOT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_valid, r_err;
  logic [31:0] r_instr, r_addr;

  logic        w_legal, w_branch, w_rtype, w_jtype;
  logic [4:0]  w_rs, w_rt, w_rd, w_sh;
  logic [5:0]  w_fn, w_op;
  logic [31:0] w_enc;
  logic        w_free, w_acc, w_load;

  always_comb begin
    w_legal  = 1'b1;
    w_branch = 1'b0;
    w_rtype  = (in_mnem < 6'd18);
    w_jtype  = 1'b0;
    w_rs     = in_rs;
    w_rt     = in_rt;
    w_rd     = in_rd;
    w_sh     = 5'd0;
    w_fn     = 6'h00;
    w_op     = 6'h00;
    case (in_mnem)
      6'd0:  w_fn = 6'h20;
      6'd1:  w_fn = 6'h21;
      6'd2:  w_fn = 6'h22;
      6'd3:  w_fn = 6'h23;
      6'd4:  w_fn = 6'h24;
      6'd5:  w_fn = 6'h25;
      6'd6:  w_fn = 6'h26;
      6'd7:  w_fn = 6'h27;
      6'd8:  w_fn = 6'h2A;
      6'd9:  w_fn = 6'h2B;
      6'd10: begin w_fn = 6'h00; w_rs = 5'd0; w_sh = in_shamt; end
      6'd11: w_fn = 6'h04;
      6'd12: begin w_fn = 6'h03; w_rs = 5'd0; w_sh = in_shamt; end
      6'd13: w_fn = 6'h07;
      6'd14: begin w_fn = 6'h02; w_rs = 5'd0; w_sh = in_shamt; end
      6'd15: w_fn = 6'h06;
      6'd16: begin
        w_fn     = 6'h09;
        w_rt     = 5'd0;
        w_rd     = (in_rd == 5'd0) ? 5'd31 : in_rd;
        w_branch = 1'b1;
      end
      6'd17: begin w_fn = 6'h08; w_rt = 5'd0; w_rd = 5'd0; w_branch = 1'b1; end
      6'd18: w_op = 6'h08;
      6'd19: w_op = 6'h0C;
      6'd20: w_op = 6'h0D;
      6'd21: w_op = 6'h0E;
      6'd22: begin w_op = 6'h0F; w_rs = 5'd0; end
      6'd23: w_op = 6'h0A;
      6'd24: w_op = 6'h20;
      6'd25: w_op = 6'h24;
      6'd26: w_op = 6'h21;
      6'd27: w_op = 6'h25;
      6'd28: w_op = 6'h23;
      6'd29: w_op = 6'h28;
      6'd30: w_op = 6'h29;
      6'd31: w_op = 6'h2B;
      6'd32: begin w_op = 6'h04; w_branch = 1'b1; end
      6'd33: begin w_op = 6'h05; w_branch = 1'b1; end
      6'd34: begin w_op = 6'h02; w_jtype = 1'b1; w_branch = 1'b1; end
      6'd35: begin w_op = 6'h03; w_jtype = 1'b1; w_branch = 1'b1; end
      default: w_legal = 1'b0;
    endcase
    if (w_jtype)
      w_enc = {w_op, in_target};
    else if (w_rtype)
      w_enc = {6'd0, w_rs, w_rt, w_rd, w_sh, w_fn};
    else
      w_enc = {w_op, w_rs, w_rt, in_imm};
  end

  // Output register is free when empty or being drained this cycle.
  assign w_free = !r_valid || out_ready;
  assign w_acc  = in_valid && in_ready;
  assign w_load = (w_acc && w_legal) || ((r_state == SLOT) && w_free);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ENC: begin
        in_ready = w_free;
        if (w_acc && w_legal && w_branch && slot_en)
          w_state_nxt = SLOT;
      end
      SLOT: begin
        if (w_free)
          w_state_nxt = ENC;
      end
      default: w_state_nxt = ENC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ENC;
      r_valid <= 1'b0;
      r_instr <= 32'd0;
      r_addr  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_acc && !w_legal;
      if (w_load) begin
        r_valid <= 1'b1;
        r_instr <= (r_state == SLOT) ? NOP_WORD : w_enc;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      // Address tracks the word currently presented; a base load wins.
      if (base_load)
        r_addr <= base_addr & ~32'd3;
      else if (r_valid && out_ready)
        r_addr <= r_addr + 32'd4;
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_instr_encoder: vector table, corner sequences and random stream      |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        slot_en;
  logic        base_load;
  logic [31:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  instr_encoder #(.NOP_WORD(32'h00000000)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .slot_en(slot_en),
    .base_load(base_load), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  mnem;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[12];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] q[$];
  logic [31:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic slot);
    in_valid  = 1'b1;
    in_mnem   = v.mnem;
    in_rs     = v.rs;
    in_rt     = v.rt;
    in_rd     = v.rd;
    in_shamt  = v.sh;
    in_imm    = v.imm;
    in_target = v.tgt;
    slot_en   = slot;
  endtask

  // Reference encoding built from the opcode/funct tables and field rules.
  function automatic logic [31:0] ref_enc(input logic [5:0] m, input logic [4:0] rs_i,
      input logic [4:0] rt_i, input logic [4:0] rd_i, input logic [4:0] sh_i,
      input logic [15:0] imm_i, input logic [25:0] tgt_i);
    int unsigned rfn[18] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 4, 3, 7, 2, 6, 9, 8};
    int unsigned iop[16] = '{8, 12, 13, 14, 15, 10, 32, 36, 33, 37, 35, 40, 41, 43, 4, 5};
    int unsigned rs, rt, rd, sh, mi;
    rs = rs_i; rt = rt_i; rd = rd_i; sh = sh_i; mi = m;
    if (mi < 18) begin
      if (mi == 10 || mi == 12 || mi == 14) rs = 0;
      else sh = 0;
      if (mi == 17) begin rt = 0; rd = 0; end
      if (mi == 16) begin rt = 0; if (rd == 0) rd = 31; end
      return 32'(rfn[mi] + sh * 64 + rd * 2048 + rt * 65536 + rs * 2097152);
    end else if (mi < 34) begin
      if (mi == 22) rs = 0;
      return 32'(iop[mi - 18] * 67108864 + rs * 2097152 + rt * 65536 + imm_i);
    end
    return 32'((mi - 32) * 67108864 + tgt_i);
  endfunction

  function automatic bit has_slot(input logic [5:0] m);
    return (m == 6'd16 || m == 6'd17 || m >= 6'd32) && m <= 6'd35;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v_beq, v_j;
    vecs[0]  = '{6'd0,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'h0, 32'h00221820};
    vecs[1]  = '{6'd10, 5'd7,  5'd2,  5'd3,  5'd4, 16'h0000, 26'h0, 32'h00021900};
    vecs[2]  = '{6'd18, 5'd0,  5'd1,  5'd0,  5'd0, 16'h0005, 26'h0, 32'h20010005};
    vecs[3]  = '{6'd17, 5'd31, 5'd5,  5'd6,  5'd3, 16'h0000, 26'h0, 32'h03E00008};
    vecs[4]  = '{6'd16, 5'd4,  5'd9,  5'd0,  5'd2, 16'h0000, 26'h0, 32'h0080F809};
    vecs[5]  = '{6'd22, 5'd5,  5'd3,  5'd0,  5'd0, 16'h1234, 26'h0, 32'h3C031234};
    vecs[6]  = '{6'd31, 5'd29, 5'd31, 5'd0,  5'd0, 16'hFFFC, 26'h0, 32'hAFBFFFFC};
    vecs[7]  = '{6'd35, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h0100000, 32'h0C100000};
    vecs[8]  = '{6'd3,  5'd8,  5'd9,  5'd10, 5'd7, 16'h0000, 26'h0, 32'h01095023};
    vecs[9]  = '{6'd13, 5'd1,  5'd2,  5'd3,  5'd5, 16'h0000, 26'h0, 32'h00221807};
    vecs[10] = '{6'd33, 5'd3,  5'd0,  5'd0,  5'd0, 16'h0010, 26'h0, 32'h14600010};
    vecs[11] = '{6'd7,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'h0, 32'h00221827};
    v_beq    = '{6'd32, 5'd1,  5'd2,  5'd0,  5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF};
    v_j      = '{6'd34, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h100, 32'h08000100};

    rstn = 1'b0; in_valid = 1'b0; in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0; slot_en = 1'b0; base_load = 1'b0;
    base_addr = '0; out_ready = 1'b1;
    tick; tick;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    tick;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Back-to-back table vectors at full throughput.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i], 1'b0);
      tick;
      chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
      chk($sformatf("vec%0d_addr", i), out_addr, 32'(i * 4));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_addr", out_addr, 32'd48);

    // Delay slot after BEQ, then J.
    drive(v_beq, 1'b1);
    tick;
    chk("beq_instr", out_instr, 32'h1022FFFF);
    chk("beq_addr", out_addr, 32'd48);
    drive(v_j, 1'b0);
    #1 chk("slot_ready", 32'(in_ready), 32'd0);
    tick;
    chk("nop_instr", out_instr, 32'h00000000);
    chk("nop_valid", 32'(out_valid), 32'd1);
    chk("nop_addr", out_addr, 32'd52);
    chk("post_slot_ready", 32'(in_ready), 32'd1);
    tick;
    chk("j_instr", out_instr, 32'h08000100);
    chk("j_addr", out_addr, 32'd56);
    in_valid = 1'b0;
    tick;

    // Backpressure for three cycles.
    drive(vecs[0], 1'b0);
    tick;
    chk("stall_first", out_instr, 32'h00221820);
    out_ready = 1'b0;
    drive(vecs[11], 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", 32'(in_ready), 32'd0);
      tick;
      chk("stall_instr", out_instr, 32'h00221820);
      chk("stall_addr", out_addr, 32'd60);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 32'(in_ready), 32'd1);
    tick;
    chk("release_instr", out_instr, 32'h00221827);
    chk("release_addr", out_addr, 32'd64);
    in_valid = 1'b0;
    tick;

    // Illegal mnemonic.
    in_valid = 1'b1; in_mnem = 6'd40;
    tick;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_addr", out_addr, 32'd68);
    in_valid = 1'b0;
    tick;
    chk("ill_err_clr", 32'(err), 32'd0);
    chk("ill_addr2", out_addr, 32'd68);

    // Base load with concurrent transfer, then address wrap.
    drive(vecs[0], 1'b0);
    tick;
    drive(vecs[8], 1'b0);
    base_load = 1'b1; base_addr = 32'h00400003;
    tick;
    chk("base_addr", out_addr, 32'h00400000);
    chk("base_instr", out_instr, 32'h01095023);
    base_addr = 32'hFFFFFFFC;
    drive(vecs[11], 1'b0);
    tick;
    chk("top_addr", out_addr, 32'hFFFFFFFC);
    base_load = 1'b0;
    drive(vecs[2], 1'b0);
    tick;
    chk("wrap_addr", out_addr, 32'h00000000);
    chk("wrap_instr", out_instr, 32'h20010005);
    in_valid = 1'b0;
    tick;

    // Reset while a branch is held and the delay slot is pending.
    out_ready = 1'b0;
    drive(v_beq, 1'b1);
    tick;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick;
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr", out_instr, 32'd0);
    chk("async_rst_addr", out_addr, 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    #2 rstn = 1'b1;
    out_ready = 1'b1;
    slot_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("no_nop_valid", 32'(out_valid), 32'd0);
      chk("no_nop_ready", 32'(in_ready), 32'd1);
    end

    // Random stream against the transaction-level reference.
    m_addr = 32'd0;
    for (int c = 0; c < 2004; c++) begin
      bit acc, xfer, exp_err;
      if (c < 2000) begin
        in_valid  = ($urandom_range(3) != 0);
        in_mnem   = ($urandom_range(7) == 0) ? 6'(36 + $urandom_range(27)) : 6'($urandom_range(35));
        in_rs     = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
        in_shamt  = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
        slot_en   = 1'($urandom);
        out_ready = ($urandom_range(3) != 0);
        base_load = ($urandom_range(31) == 0);
        base_addr = $urandom;
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; base_load = 1'b0;
      end
      #1;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", out_instr, 32'hDEADBEEF);
        end else begin
          chk("rnd_instr", out_instr, q[0]);
          chk("rnd_addr", out_addr, m_addr);
          void'(q.pop_front());
        end
      end
      if (base_load) m_addr = base_addr & 32'hFFFFFFFC;
      else if (xfer) m_addr = m_addr + 32'd4;
      exp_err = acc && (in_mnem > 6'd35);
      if (acc && in_mnem <= 6'd35) begin
        q.push_back(ref_enc(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target));
        if (slot_en && has_slot(in_mnem)) q.push_back(32'h00000000);
      end
      tick;
      chk("rnd_err", 32'(err), 32'(exp_err));
    end
    chk("rnd_leftover", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
